// File: rtl/mod_pkg.sv
// Shared types and constants for the BPSK modulator and the clock-divider stage.
package mod_pkg;

    localparam int unsigned DEF_ACC_W     = 24;
    localparam int unsigned DEF_PHASE_INC = 16777;
    localparam int unsigned LUT_AW        = 5;
    localparam int unsigned DAC_W         = 8;
    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned BIT_CNT_W     = 3;

    localparam logic [DAC_W-1:0] DAC_MID = DAC_W'(1 << (DAC_W - 1));

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

endpackage

// File: rtl/sine_lut.sv
// Registered 32-entry unsigned sine ROM: round(127.5 + 127.5*sin(2*pi*k/32)).
module sine_lut
    import mod_pkg::*;
(
    input  logic              clk,
    input  logic [LUT_AW-1:0] addr,
    output logic [DAC_W-1:0]  q
);

    logic [DAC_W-1:0] rom_c;

    // Table lookup.
    always_comb begin
        rom_c = DAC_MID;
        case (addr)
            5'd0:  rom_c = 8'd128;
            5'd1:  rom_c = 8'd152;
            5'd2:  rom_c = 8'd176;
            5'd3:  rom_c = 8'd198;
            5'd4:  rom_c = 8'd218;
            5'd5:  rom_c = 8'd234;
            5'd6:  rom_c = 8'd245;
            5'd7:  rom_c = 8'd253;
            5'd8:  rom_c = 8'd255;
            5'd9:  rom_c = 8'd253;
            5'd10: rom_c = 8'd245;
            5'd11: rom_c = 8'd234;
            5'd12: rom_c = 8'd218;
            5'd13: rom_c = 8'd198;
            5'd14: rom_c = 8'd176;
            5'd15: rom_c = 8'd152;
            5'd16: rom_c = 8'd128;
            5'd17: rom_c = 8'd103;
            5'd18: rom_c = 8'd79;
            5'd19: rom_c = 8'd57;
            5'd20: rom_c = 8'd37;
            5'd21: rom_c = 8'd21;
            5'd22: rom_c = 8'd10;
            5'd23: rom_c = 8'd2;
            5'd24: rom_c = 8'd0;
            5'd25: rom_c = 8'd2;
            5'd26: rom_c = 8'd10;
            5'd27: rom_c = 8'd21;
            5'd28: rom_c = 8'd37;
            5'd29: rom_c = 8'd57;
            5'd30: rom_c = 8'd79;
            5'd31: rom_c = 8'd103;
            default: rom_c = DAC_MID;
        endcase
    end

    // Output register: one clock of latency from addr to q.
    always_ff @(posedge clk) begin
        q <= rom_c;
    end

endmodule

// File: rtl/bpsk_modulator.sv
// BPSK modulator: byte handshake in, MSB-first bit serialiser, phase-accumulator
// sine carrier with 180-degree flips for 0 bits.
// Optional build macro DIFF_ENC_EN: differential symbol encoding (0 bit toggles phase).
module bpsk_modulator
    import mod_pkg::*;
#(
    parameter int unsigned ACC_W     = DEF_ACC_W,
    parameter int unsigned PHASE_INC = DEF_PHASE_INC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_tick,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic [DAC_W-1:0]  dac_out,
    output logic              tx_active,
    output logic              tx_bit
);

    tx_state_t             state;
    logic [ACC_W-1:0]      acc;
    logic [BYTE_W-2:0]     shreg;      // bits still waiting to go on air
    logic [BIT_CNT_W-1:0]  bitcnt;
    logic                  sym;
    logic                  xfer;
    logic                  shift_en;
    logic                  stop;
    logic [LUT_AW-1:0]     lut_addr;
    logic [DAC_W-1:0]      lut_q;

    // Handshake and bit-boundary events; ready reopens only on the last bit boundary.
    always_comb begin
        data_ready = ~rst & ((state == IDLE) |
                             ((state == SHIFT) & bit_tick & (bitcnt == '0)));
        xfer       = data_valid & data_ready;
        shift_en   = (state == SHIFT) & bit_tick & (bitcnt != '0);
        stop       = (state == SHIFT) & bit_tick & (bitcnt == '0) & ~xfer;
    end

    // Serialiser FSM with registered tx_active/tx_bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bitcnt    <= '0;
            tx_bit    <= 1'b0;
            tx_active <= 1'b0;
        end else if (xfer) begin
            state     <= SHIFT;
            tx_active <= 1'b1;
            shreg     <= data_in[BYTE_W-2:0];
            bitcnt    <= BIT_CNT_W'(BYTE_W - 1);
            tx_bit    <= data_in[BYTE_W-1];
        end else if (shift_en) begin
            shreg     <= {shreg[BYTE_W-3:0], 1'b0};
            bitcnt    <= bitcnt - BIT_CNT_W'(1);
            tx_bit    <= shreg[BYTE_W-2];
        end else if (stop) begin
            state     <= IDLE;
            tx_active <= 1'b0;
            tx_bit    <= 1'b0;
        end
    end

`ifdef DIFF_ENC_EN
    // Differential symbol: a 0 bit toggles carrier phase, a 1 keeps it; parks at 1 in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym <= 1'b1;
        end else if (xfer) begin
            sym <= sym ^ ~data_in[BYTE_W-1];
        end else if (shift_en) begin
            sym <= sym ^ ~shreg[BYTE_W-2];
        end else if (stop) begin
            sym <= 1'b1;
        end
    end
`else
    // Absolute BPSK: the symbol is the raw data bit.
    always_comb begin
        sym = tx_bit;
    end
`endif

    // Free-running phase accumulator, wraps modulo 2^ACC_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else begin
            acc <= acc + ACC_W'(PHASE_INC);
        end
    end

    // Top phase bits select the LUT entry; sym=0 flips the MSB for +180 degrees.
    always_comb begin
        lut_addr = acc[ACC_W-1 -: LUT_AW] ^ {~sym, {(LUT_AW-1){1'b0}}};
    end

    sine_lut u_sine_lut (
        .clk  (clk),
        .addr (lut_addr),
        .q    (lut_q)
    );

    // Silence (mid-scale) whenever no bit is on air.
    always_comb begin
        dac_out = tx_active ? lut_q : DAC_MID;
    end

endmodule

// File: tb/tb_bpsk_modulator.sv
// Testbench for bpsk_modulator: per-cycle behavioural model plus directed scenarios.
module tb_bpsk_modulator;

`ifdef DIFF_ENC_EN
    localparam bit DIFF = 1'b1;
`else
    localparam bit DIFF = 1'b0;
`endif
    localparam longint CARRIER_INC = 16777;
    localparam longint ACC_MOD     = 64'd1 << 24;
    localparam real    PI          = 3.14159265358979;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_tick = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic [7:0] dac_out;
    logic       tx_active;
    logic       tx_bit;

    int checks   = 0;
    int failures = 0;
    bit run_cmp  = 1'b0;

    bpsk_modulator dut (
        .clk        (clk),
        .rst        (rst),
        .bit_tick   (bit_tick),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .dac_out    (dac_out),
        .tx_active  (tx_active),
        .tx_bit     (tx_bit)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic check_tol(input string name, input int got, input int exp, input int tol);
        checks++;
        if (got > exp + tol || got < exp - tol) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d+/-%0d t=%0t", name, got, exp, tol, $time);
        end
    endtask

    // Reference sine table from the closed-form definition.
    int lut_ref[32];
    initial begin
        for (int k = 0; k < 32; k++)
            lut_ref[k] = $rtoi($floor(127.5 + 127.5 * $sin(2.0 * PI * k / 32.0) + 0.5));
    end

    // Behavioural model: which bit of which byte is on air, the carrier phase and the symbol.
    bit       m_busy = 1'b0;
    bit [7:0] m_byte = 8'h00;
    int       m_idx  = 0;
    longint   m_acc  = 0;
    bit       m_sym  = DIFF;
    bit       m_txb  = 1'b0;
    int       m_dac  = 128;

    task automatic model_put_bit(input bit b);
        m_txb = b;
        m_sym = DIFF ? (m_sym ^ !b) : b;
    endtask

    always @(posedge clk) begin : model
        int lq;
        bit take;
        if (rst) begin
            m_busy = 1'b0; m_idx = 0; m_acc = 0; m_txb = 1'b0; m_sym = DIFF; m_dac = 128;
        end else begin
            lq   = lut_ref[int'((m_acc >> 19) % 32) ^ (m_sym ? 0 : 16)];
            take = data_valid && (!m_busy || (bit_tick && m_idx == 0));
            m_acc = (m_acc + CARRIER_INC) % ACC_MOD;
            if (take) begin
                m_busy = 1'b1; m_byte = data_in; m_idx = 7;
                model_put_bit(m_byte[7]);
            end else if (m_busy && bit_tick) begin
                if (m_idx > 0) begin
                    m_idx--;
                    model_put_bit(m_byte[m_idx]);
                end else begin
                    m_busy = 1'b0; m_txb = 1'b0; m_sym = DIFF;
                end
            end
            m_dac = m_busy ? lq : 128;
        end
    end

    // Per-cycle comparison, sampled mid-cycle.
    always @(negedge clk) begin : compare
        int exp_ready;
        if (run_cmp) begin
            if (rst) begin
                check("rst_dac", int'(dac_out), 128);
                check("rst_active", int'(tx_active), 0);
                check("rst_ready", int'(data_ready), 0);
                check("rst_tx_bit", int'(tx_bit), 0);
            end else begin
                exp_ready = (!m_busy || (bit_tick && m_idx == 0)) ? 1 : 0;
                check("dac", int'(dac_out), m_dac);
                check("active", int'(tx_active), int'(m_busy));
                check("ready", int'(data_ready), exp_ready);
                if (m_busy) check("tx_bit", int'(tx_bit), int'(m_txb));
            end
        end
    end

    // Bit-tick generator: stopped (tick_per=0), fixed period, or random 20..80 clk.
    int tick_per  = 0;
    bit tick_rand = 1'b0;
    initial begin : tick_gen
        int cnt;
        int per;
        cnt = 0; per = 0;
        forever begin
            @(posedge clk); #1;
            if (tick_per == 0 && !tick_rand) begin
                cnt = 0; per = 0; bit_tick = 1'b0;
            end else begin
                if (per == 0) per = tick_rand ? int'($urandom_range(20, 80)) : tick_per;
                cnt++;
                if (cnt >= per) begin
                    bit_tick = 1'b1; cnt = 0;
                    per = tick_rand ? int'($urandom_range(20, 80)) : tick_per;
                end else begin
                    bit_tick = 1'b0;
                end
            end
        end
    end

    // Present a byte and return just after it has been accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        data_in = b; data_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (data_ready) break;
            n++;
            if (n > 20000) begin
                check("ready_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        data_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (!tx_active) break;
            n++;
            if (n > 30000) begin
                check("idle_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_tick_edge();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (bit_tick) break;
            n++;
            if (n > 5000) begin
                check("tick_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    int exp_a5[8] = '{1, 0, 1, 0, 0, 1, 0, 1};

    initial begin : main
        int a, b, ta, tb;
        int cyc, last_x, nx, prev;
        int ticks, rdy, xfer_tick, n;

        @(posedge clk); #1;
        run_cmp = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Pin the reference table with hand-computed entries.
        check("lut_k0", lut_ref[0], 128);
        check("lut_k1", lut_ref[1], 152);
        check("lut_k8", lut_ref[8], 255);
        check("lut_k17", lut_ref[17], 103);
        check("lut_k24", lut_ref[24], 0);

        // Single byte 0xA5: bit sequence and return to silence.
        send_byte(8'hA5);
        tick_per = 200;
        for (int i = 0; i < 8; i++) begin
            repeat (5) @(negedge clk);
            check("t2_bit", int'(tx_bit), exp_a5[i]);
            wait_tick_edge();
        end
        tick_per = 0;
        @(negedge clk);
        check("t2_idle_active", int'(tx_active), 0);
        check("t2_idle_dac", int'(dac_out), 128);
        @(posedge clk); #1;

        // Carrier period from rising crossings through mid-scale on 0xFF.
        send_byte(8'hFF);
        tick_per = 2500;
        repeat (20) @(negedge clk);
        prev = int'(dac_out); last_x = -1; nx = 0; cyc = 0;
        while (nx < 6 && cyc < 9000) begin
            @(negedge clk); cyc++;
            if (prev < 128 && int'(dac_out) >= 128) begin
                if (last_x >= 0) check_tol("t3_period", cyc - last_x, 1000, 1);
                last_x = cyc; nx++;
            end
            prev = int'(dac_out);
        end
        check("t3_crossings", nx, 6);
        wait_idle();
        tick_per = 0;

        // Phase flip 1 -> 0 on 0x80: samples one carrier period apart are mirrored.
        send_byte(8'h80);
        tick_per = 1000;
        repeat (500) @(negedge clk);
        a = int'(dac_out); ta = int'(tx_bit);
        repeat (1000) @(negedge clk);
        b = int'(dac_out); tb = int'(tx_bit);
        check("t4_bit0", ta, 1);
        check("t4_bit1", tb, 0);
        check_tol("t4_antiphase_sum", a + b, 255, 1);
        wait_idle();
        tick_per = 0;

        // 0x00: phase inverts per bit only with differential encoding.
        send_byte(8'h00);
        tick_per = 1000;
        repeat (500) @(negedge clk);
        a = int'(dac_out);
        repeat (1000) @(negedge clk);
        b = int'(dac_out);
        if (DIFF) check_tol("t6_diff_sum", a + b, 255, 1);
        else      check_tol("t6_abs_same", b - a, 0, 1);
        wait_idle();
        tick_per = 0;

        // Back-to-back 0x0F then 0xF0 with valid held.
        send_byte(8'h0F);
        tick_per = 50;
        data_in = 8'hF0; data_valid = 1'b1;
        ticks = 0; rdy = 0; xfer_tick = 0; n = 0;
        while (n < 2000) begin
            @(negedge clk); n++;
            if (!tx_active) break;
            if (bit_tick) ticks++;
            if (data_ready) begin
                rdy++;
                if (data_valid) begin
                    xfer_tick = ticks;
                    @(posedge clk); #1;
                    data_valid = 1'b0;
                end
            end
        end
        check("t5_reload_on_tick", xfer_tick, 8);
        check("t5_contiguous_ticks", ticks, 16);
        check("t5_ready_pulses", rdy, 2);
        tick_per = 0;
        @(posedge clk); #1;

        // Randomised traffic with a reset dropped into the middle of a byte.
        tick_rand = 1'b1;
        for (int i = 0; i < 25; i++) begin
            send_byte(8'($urandom));
            if (i == 12) begin
                repeat ($urandom_range(30, 200)) @(posedge clk);
                #1 rst = 1'b1;
                repeat (3) @(posedge clk);
                #1 rst = 1'b0;
                @(negedge clk);
                check("t1_ready_after_release", int'(data_ready), 1);
                check("t1_active_after_release", int'(tx_active), 0);
                check("t1_dac_after_release", int'(dac_out), 128);
                @(posedge clk); #1;
            end else if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 400)) @(posedge clk);
                #1;
            end
        end
        wait_idle();
        tick_rand = 1'b0;
        repeat (5) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
